// File: rtl/serial_subtractor4.sv
// Bit-serial 4-bit two's complement subtractor: a - b computed LSB first as a + ~b + 1,
// then borrow, signed overflow, sign and magnitude of the exact 5-bit result.
module serial_subtractor4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [3:0] diff,
  output logic       borrow,
  output logic       ovf,
  output logic       sign,
  output logic [3:0] mag
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [3:0]  r_a;
  logic [3:0]  r_b;
  logic        r_carry;
  logic [1:0]  r_idx;
  logic        r_busy;
  logic        r_done;
  logic [3:0]  r_diff;
  logic        r_borrow;
  logic        r_ovf;
  logic        r_sign;
  logic [3:0]  r_mag;

  logic        w_abit;
  logic        w_nbbit;
  logic        w_sum;
  logic        w_cout;
  logic        w_rsign;
  logic signed [4:0] w_r;

  // |r| for r in -15..15 always fits in 4 bits.
  function automatic logic [3:0] abs_mag(input logic signed [4:0] r);
    logic signed [4:0] n;
    n = (r < 0) ? -r : r;
    return n[3:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (r_idx == 2'd3) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // One full-adder slice of a + ~b, plus the sign bit of the sign-extended result.
  assign w_abit  = r_a[r_idx];
  assign w_nbbit = ~r_b[r_idx];
  assign w_sum   = w_abit ^ w_nbbit ^ r_carry;
  assign w_cout  = (w_abit & w_nbbit) | (w_abit & r_carry) | (w_nbbit & r_carry);
  assign w_rsign = r_a[3] ^ ~r_b[3] ^ r_carry;
  assign w_r     = {w_rsign, r_diff};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= 4'd0;
      r_b      <= 4'd0;
      r_carry  <= 1'b0;
      r_idx    <= 2'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= 4'd0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_sign   <= 1'b0;
      r_mag    <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b1;
            r_idx   <= 2'd0;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          r_diff[r_idx] <= w_sum;
          r_carry       <= w_cout;
          // Index parks at 3 so no fifth bit is ever processed.
          if (r_idx != 2'd3) r_idx <= r_idx + 2'd1;
        end
        FINISH: begin
          r_borrow <= ~r_carry;
          r_ovf    <= (r_a[3] != r_b[3]) && (r_diff[3] != r_a[3]);
          r_sign   <= w_rsign;
          r_mag    <= abs_mag(w_r);
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign ovf    = r_ovf;
  assign sign   = r_sign;
  assign mag    = r_mag;

endmodule

// File: tb/tb_serial_subtractor4.sv
// Directed self-checking bench for serial_subtractor4 with hand-computed expectations.
module tb_serial_subtractor4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       borrow;
  logic       ovf;
  logic       sign;
  logic [3:0] mag;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  serial_subtractor4 dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf),
    .sign   (sign),
    .mag    (mag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_results(input string tag, input logic [3:0] e_diff, input logic e_borrow,
                             input logic e_ovf, input logic e_sign, input logic [3:0] e_mag);
    chk({tag, " diff"},   {4'd0, diff},   {4'd0, e_diff});
    chk({tag, " borrow"}, {7'd0, borrow}, {7'd0, e_borrow});
    chk({tag, " ovf"},    {7'd0, ovf},    {7'd0, e_ovf});
    chk({tag, " sign"},   {7'd0, sign},   {7'd0, e_sign});
    chk({tag, " mag"},    {4'd0, mag},    {4'd0, e_mag});
  endtask

  // Full operation: accept edge, four SHIFT edges, FINISH edge, then one hold cycle.
  task automatic run_op(input string tag, input logic [3:0] va, input logic [3:0] vb,
                        input logic [3:0] e_diff, input logic e_borrow, input logic e_ovf,
                        input logic e_sign, input logic [3:0] e_mag);
    a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy after accept"}, {7'd0, busy}, 8'd1);
    repeat (4) tick();
    chk({tag, " done early"}, {7'd0, done}, 8'd0);
    chk({tag, " busy in finish"}, {7'd0, busy}, 8'd1);
    tick();
    chk({tag, " done"}, {7'd0, done}, 8'd1);
    chk({tag, " busy with done"}, {7'd0, busy}, 8'd0);
    chk_results(tag, e_diff, e_borrow, e_ovf, e_sign, e_mag);
    tick();
    chk({tag, " done one cycle"}, {7'd0, done}, 8'd0);
    chk({tag, " hold diff"}, {4'd0, diff}, {4'd0, e_diff});
    chk({tag, " hold mag"}, {4'd0, mag}, {4'd0, e_mag});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
    tick();
    start = 1'b1;
    tick();
    chk("reset busy", {7'd0, busy}, 8'd0);
    chk("reset done", {7'd0, done}, 8'd0);
    chk_results("reset", 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    start = 1'b0;
    rst = 1'b0;
    tick();

    run_op("5-3",   4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010);
    run_op("3-5",   4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0, 1'b1, 4'b0010);
    run_op("7-(-8)", 4'b0111, 4'b1000, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b1111);
    run_op("-8-1",  4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b1, 4'b1001);
    run_op("-1-7",  4'b1111, 4'b0111, 4'b1000, 1'b0, 1'b0, 1'b1, 4'b1000);
    run_op("0-0",   4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Idle with start low: outputs keep the last result.
    repeat (3) tick();
    chk("idle hold busy", {7'd0, busy}, 8'd0);
    chk_results("idle hold", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Start re-pulse and operand change while busy are ignored.
    done_cnt = 0;
    a = 4'b0101; b = 4'b0011; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; a = 4'b0000; b = 4'b0111;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("ignore done early", {7'd0, done}, 8'd0);
    tick();
    chk("ignore done", {7'd0, done}, 8'd1);
    chk_results("ignore", 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010);
    repeat (8) tick();
    chk("ignore done count", done_cnt[7:0], 8'd1);
    chk("ignore idle busy", {7'd0, busy}, 8'd0);

    // Reset in SHIFT cycle 3 clears everything and suppresses done.
    done_cnt = 0;
    a = 4'b0111; b = 4'b1000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy", {7'd0, busy}, 8'd0);
    chk("midrst done", {7'd0, done}, 8'd0);
    chk_results("midrst", 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (6) tick();
    chk("midrst no done", done_cnt[7:0], 8'd0);
    run_op("post-rst -8-1", 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b1, 4'b1001);

    // Start held high restarts in the IDLE cycle right after done.
    done_cnt = 0;
    a = 4'b0011; b = 4'b0101; start = 1'b1;
    tick();
    repeat (5) tick();
    chk("held done 1", {7'd0, done}, 8'd1);
    chk_results("held 1", 4'b1110, 1'b1, 1'b0, 1'b1, 4'b0010);
    a = 4'b0101; b = 4'b0011;
    tick();
    chk("held reaccept busy", {7'd0, busy}, 8'd1);
    start = 1'b0;
    repeat (5) tick();
    chk("held done 2", {7'd0, done}, 8'd1);
    chk_results("held 2", 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010);
    tick();
    chk("held done count", done_cnt[7:0], 8'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor4.md
SERIAL_SUBTRACTOR4 -- requirements
Module: serial_subtractor4

Interface
REQ-001 SHALL have exactly these ports, and no others, in this order:
 clk  input  1  single clock; all state changes on rising edge
 rst  input  1  synchronous reset, active-high
 start  input  1  request; accepted only in IDLE
 a  input  4  minuend, two's complement
 b  input  4  subtrahend, two's complement
 busy  output  1  high in SHIFT and FINISH
 done  output  1  one-cycle pulse, results valid
 diff  output  4  a - b modulo 16, two's complement
 borrow  output  1  unsigned borrow: 1 when a < b as unsigned values
 ovf  output  1  signed overflow of the 4-bit diff
 sign  output  1  sign of the true signed result, 1 = negative
 mag  output  4  magnitude of the true signed result (range 0..15)
REQ-002 SHALL have no parameters; the width is fixed at 4.

Function
REQ-003 SHALL implement a state machine with states IDLE, SHIFT and FINISH.
REQ-004 IDLE with start=1 at an edge: SHALL latch a and b, load carry=1, clear the bit index to 0 and go to SHIFT.
REQ-005 IDLE with start=0: SHALL remain in IDLE, and all outputs SHALL hold their values.
REQ-006 SHIFT: each edge SHALL compute one bit, LSB first.
 - diff[i] = a[i] ^ ~b[i] ^ carry.
 - carry = majority(a[i], ~b[i], carry).
REQ-007 SHIFT: after the edge that processes i=3, the state SHALL go to FINISH; the index SHALL NOT wrap into a fifth bit.
REQ-008 FINISH: the edge leaving it SHALL update borrow, ovf, sign and mag, SHALL assert done for exactly one cycle, and SHALL return to IDLE.
 - borrow = ~final carry.
 - ovf = (a[3] != b[3]) and (diff[3] != a[3]).
REQ-009 The true result SHALL be the 5-bit value r = sext(a) - sext(b), with r[4] = a[3] ^ ~b[3] ^ final carry.
 - sign = r[4].
 - mag = |r|, truncated to 4 bits; it always fits, because r is in -15..15.
REQ-010 Latency: with start accepted at edge k, done SHALL be high during the cycle after edge k+5; four SHIFT edges plus one FINISH edge separate consecutive accepts.
REQ-011 busy SHALL be 1 from the accepting edge until the edge that raises done; busy and done SHALL never be high together.
REQ-012 start while busy=1 SHALL be ignored, and changes on a or b while busy=1 SHALL NOT affect the result.
REQ-013 Outputs SHALL hold the last results until the next FINISH completes.
 - diff SHALL update bit by bit during SHIFT.
 - Consumers SHALL sample only while done=1.
REQ-014 start held high continuously SHALL start a new operation in the IDLE cycle immediately following done.
REQ-015 Outputs SHALL be registered, with no combinational path from the inputs to the outputs.

Reset
REQ-016 rst=1 at an edge SHALL force IDLE and clear diff, borrow, ovf, sign, mag, busy, done, the carry register and the bit index to 0.
REQ-017 rst SHALL take priority over start and over every state, including a reset arriving mid-SHIFT or in FINISH.
REQ-018 A reset mid-operation SHALL NOT produce a done pulse.
REQ-019 The first start after rst is released SHALL be accepted normally.

Verification
REQ-020 a=0101, b=0011, start pulse -> after 5 cycles done=1, diff=0010, borrow=0, ovf=0, sign=0, mag=0010.
REQ-021 a=0011, b=0101 -> diff=1110, borrow=1, ovf=0, sign=1, mag=0010.
REQ-022 a=0111 (+7), b=1000 (-8) -> diff=1111, borrow=1, ovf=1, sign=0, mag=1111 (+15).
REQ-023 a=1000 (-8), b=0001 -> diff=0111, borrow=0, ovf=1, sign=1, mag=1001 (-9).
REQ-024 Start accepted, then start re-pulsed and a/b changed in SHIFT cycle 2 -> exactly one done, and results match the originally latched operands.
REQ-025 rst asserted in SHIFT cycle 3 -> next cycle busy=0 and all outputs 0, no done pulse; a following start produces a correct result 5 cycles later.
